pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Generic parametrised pipeline-stage register for the next-generation core; it replaces per-boundary ad-hoc registers (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload plus hazard metadata: register-write enable, destination register and Tnew.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure needs no combinational ready path.
- Adds synchronous flush and bubble masking. Tnew is decremented with saturation on capture, so each stage presents a correct Tnew to the hazard unit.

Parameters:
- DATA_W, 64, width of opaque payload (PC, PC+8, operands, immediate, control fields packed by caller).
- DST_W, 5, width of destination-register index.
- TNEW_W, 2, width of Tnew field.
- TNEW_DEC, 1, amount subtracted from Tnew on capture; saturates at 0. A value of 0 disables the decrement.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries (branch kill / bubble insertion).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_data  in  DATA_W  upstream payload.
- in_regwrite  in  1  entry writes the register file.
- in_dst  in  DST_W  destination register.
- in_tnew  in  TNEW_W  Tnew as seen by upstream.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_W  head payload.
- out_regwrite  out  1  head regwrite, masked.
- out_dst  out  DST_W  head destination, masked.
- out_tnew  out  TNEW_W  head Tnew, masked.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Transfer definitions: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- Storage: two entries, main (head) and skid, each holding {data, regwrite, dst, tnew}.
- Captured Tnew = max(in_tnew - TNEW_DEC, 0), computed at TNEW_W bits. There is no underflow wrap. Tnew does not change while an entry is held.
- Control states: EMPTY, ONE, TWO.
- in_ready = (state != TWO) & ~reset. It is a function of the state register only; there is no path from out_ready.
- out_valid = (state != EMPTY).
- Bubble masking: when out_valid=0, out_data, out_regwrite, out_dst and out_tnew are all 0.
- EMPTY state: in_xfer -> ONE, main<=in; otherwise stay in EMPTY.
- ONE state:
  - in_xfer & out_xfer -> ONE, main<=in.
  - in_xfer only -> TWO, skid<=in.
  - out_xfer only -> EMPTY.
  - neither -> hold.
- TWO state: out_xfer -> ONE, main<=skid; otherwise hold. in_xfer is impossible because in_ready=0.
- Latency: 1 cycle from in_xfer to out_valid when the stage is empty. Throughput is 1 entry/cycle while out_ready=1.
- Ordering is strict FIFO; entries are never dropped or duplicated except by flush or reset.
- flush (priority over all transfers): next edge -> EMPTY, both entries zeroed.
  - Any in_xfer in the flush cycle is discarded.
  - Any out_xfer in the flush cycle still counts downstream; the downstream stage decides.
- reset asynchronous: state -> EMPTY immediately and all storage -> 0. All outputs read 0, including in_ready.
  - The first capture is possible on the first rising edge after reset deasserts.
  - Reset mid-transfer drops all entries.
- occupancy: EMPTY=0, ONE=1, TWO=2. It is registered and reflects the state after the edge.
- Storage zeroing on dequeue is not required; the masking rules make it invisible.

Decomposition:
- Shared package pipe_pkg:
  - state enum {EMPTY, ONE, TWO}.
  - Default widths DST_W=5, TNEW_W=2.
  - Saturating-decrement function sat_dec(value, amount).
- One sub-module is natural: pipe_entry_reg, a single entry register with load and clear, instantiated twice (main, skid).
- The control FSM stays in the top module.

Test Plan:
- Reset then streaming: out_ready=1, push in_tnew=2, dst=7, data=0x1234 -> next cycle out_valid=1, out_tnew=1, out_dst=7, out_data=0x1234; 4 back-to-back pushes emerge in order, one per cycle.
- Back-pressure: out_ready=0, push A, B -> occupancy=2, in_ready=0, in_valid held with C ignored; raise out_ready -> A, B, C emerge in order with no loss.
- Saturation: in_tnew=0, TNEW_DEC=1 -> out_tnew=0, not 3; TNEW_DEC=0 instance with in_tnew=2 -> out_tnew=2.
- Flush with full buffer and simultaneous in_valid=1 -> next cycle occupancy=0, out_valid=0, out_regwrite=0, out_dst=0, out_tnew=0; flushed input never appears.
- Asynchronous reset asserted mid-cycle with occupancy=2 -> outputs 0 immediately, before the next edge; after deassert, the first push appears one cycle later.
- Random valid/ready stress: 10k cycles against a reference queue model -> order preserved, no duplicate, and in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic pipeline-stage register family.
//   - state_e   : occupancy state of a 2-entry skid stage (EMPTY, ONE, TWO)
//   - *_DEF     : default field widths used by the stage and its entry register
//   - SAT_W     : working width of the saturating-decrement helper
//   - sat_dec() : value - amount, clamped at zero (no underflow wrap)
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Occupancy state of the stage; the encoding equals the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 64;
    localparam int DST_W_DEF  = 5;
    localparam int TNEW_W_DEF = 2;

    // Tnew fields up to SAT_W bits wide are handled by sat_dec.
    localparam int SAT_W = 8;

    // Saturating subtract: returns value - amount, or zero when amount
    // would take the result below zero.
    function automatic logic [SAT_W-1:0] sat_dec(
        input logic [SAT_W-1:0] value,
        input logic [SAT_W-1:0] amount
    );
        logic [SAT_W-1:0] result;
        if (value >= amount) begin
            result = value - amount;
        end else begin
            result = {SAT_W{1'b0}};
        end
        return result;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_entry_reg.sv
// -----------------------------------------------------------------------------
// pipe_entry_reg
// One storage entry of a pipeline stage: payload plus hazard metadata.
// Clear has priority over load; reset zeroes the entry asynchronously.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset, zeroes the entry
//   clear      in   synchronous clear (flush), wins over load
//   load       in   capture d_* on the next rising edge
//   d_data     in   DATA_W  payload to capture
//   d_regwrite in   1       register-write enable to capture
//   d_dst      in   DST_W   destination register to capture
//   d_tnew     in   TNEW_W  Tnew to capture (already adjusted by the caller)
//   q_*        out          held entry
// -----------------------------------------------------------------------------
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DST_W  = DST_W_DEF,
    parameter int TNEW_W = TNEW_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_regwrite,
    input  logic [DST_W-1:0]  d_dst,
    input  logic [TNEW_W-1:0] d_tnew,
    output logic [DATA_W-1:0] q_data,
    output logic              q_regwrite,
    output logic [DST_W-1:0]  q_dst,
    output logic [TNEW_W-1:0] q_tnew
);

    // Entry storage: reset/clear zero it, load captures, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_data     <= {DATA_W{1'b0}};
            q_regwrite <= 1'b0;
            q_dst      <= {DST_W{1'b0}};
            q_tnew     <= {TNEW_W{1'b0}};
        end else if (clear) begin
            q_data     <= {DATA_W{1'b0}};
            q_regwrite <= 1'b0;
            q_dst      <= {DST_W{1'b0}};
            q_tnew     <= {TNEW_W{1'b0}};
        end else if (load) begin
            q_data     <= d_data;
            q_regwrite <= d_regwrite;
            q_dst      <= d_dst;
            q_tnew     <= d_tnew;
        end
    end

endmodule : pipe_entry_reg

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Generic pipeline-stage register with a 2-entry skid buffer. Carries an opaque
// payload plus hazard metadata (regwrite, destination, Tnew). in_ready depends
// only on the state register (and reset), never on out_ready, so back-pressure
// does not form a combinational path through the stage. Tnew is decremented
// with saturation when an entry is captured from upstream.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset; drops all entries
//   flush        in   synchronous clear of all entries, beats any transfer
//   in_valid     in   upstream entry valid
//   in_ready     out  stage can accept an entry
//   in_data      in   DATA_W  upstream payload
//   in_regwrite  in   entry writes the register file
//   in_dst       in   DST_W   destination register
//   in_tnew      in   TNEW_W  Tnew as seen upstream
//   out_valid    out  head entry valid
//   out_ready    in   downstream accepts the head
//   out_data     out  DATA_W  head payload (0 when not valid)
//   out_regwrite out  head regwrite (0 when not valid)
//   out_dst      out  DST_W   head destination (0 when not valid)
//   out_tnew     out  TNEW_W  head Tnew (0 when not valid)
//   occupancy    out  2       number of held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DST_W    = DST_W_DEF,
    parameter int TNEW_W   = TNEW_W_DEF,
    parameter int TNEW_DEC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_regwrite,
    input  logic [DST_W-1:0]  in_dst,
    input  logic [TNEW_W-1:0] in_tnew,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_regwrite,
    output logic [DST_W-1:0]  out_dst,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [1:0]        occupancy
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              out_valid_r;
    logic [1:0]        occupancy_r;
    logic [1:0]        occupancy_nxt_s;

    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              main_load_s;
    logic              main_from_skid_s;
    logic              skid_load_s;

    logic [TNEW_W-1:0] tnew_cap_s;

    logic [DATA_W-1:0] main_d_data_s;
    logic              main_d_regwrite_s;
    logic [DST_W-1:0]  main_d_dst_s;
    logic [TNEW_W-1:0] main_d_tnew_s;

    logic [DATA_W-1:0] main_data_s;
    logic              main_regwrite_s;
    logic [DST_W-1:0]  main_dst_s;
    logic [TNEW_W-1:0] main_tnew_s;

    logic [DATA_W-1:0] skid_data_s;
    logic              skid_regwrite_s;
    logic [DST_W-1:0]  skid_dst_s;
    logic [TNEW_W-1:0] skid_tnew_s;

    // Reset is folded in so upstream sees "not ready" for the whole reset pulse.
    assign in_ready   = (state_r != TWO) && !reset;
    assign out_valid  = out_valid_r;
    assign occupancy  = occupancy_r;

    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid_r && out_ready;

    // Tnew is adjusted once, on entry into the stage; held entries keep their value.
    assign tnew_cap_s = TNEW_W'(sat_dec(SAT_W'(in_tnew), SAT_W'(TNEW_DEC)));

    // Next-state and entry load decode; flush overrides every transfer.
    always_comb begin
        state_nxt_s      = state_r;
        main_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) begin
                        main_load_s = 1'b1;
                        state_nxt_s = ONE;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        // Head leaves while the new entry takes its place.
                        main_load_s = 1'b1;
                        state_nxt_s = ONE;
                    end else if (in_xfer_s) begin
                        skid_load_s = 1'b1;
                        state_nxt_s = TWO;
                    end else if (out_xfer_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                TWO: begin
                    // No in_xfer possible here: in_ready is low in TWO.
                    if (out_xfer_s) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        state_nxt_s      = ONE;
                    end else begin
                        state_nxt_s = TWO;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // Entry count for the state being entered.
    always_comb begin
        case (state_nxt_s)
            EMPTY:   occupancy_nxt_s = 2'd0;
            ONE:     occupancy_nxt_s = 2'd1;
            TWO:     occupancy_nxt_s = 2'd2;
            default: occupancy_nxt_s = 2'd0;
        endcase
    end

    // Control FSM with registered out_valid and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != EMPTY);
            occupancy_r <= occupancy_nxt_s;
        end
    end

    // Main entry refills from the skid entry when draining TWO, else from upstream.
    always_comb begin
        if (main_from_skid_s) begin
            main_d_data_s     = skid_data_s;
            main_d_regwrite_s = skid_regwrite_s;
            main_d_dst_s      = skid_dst_s;
            main_d_tnew_s     = skid_tnew_s;
        end else begin
            main_d_data_s     = in_data;
            main_d_regwrite_s = in_regwrite;
            main_d_dst_s      = in_dst;
            main_d_tnew_s     = tnew_cap_s;
        end
    end

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .DST_W  (DST_W),
        .TNEW_W (TNEW_W)
    ) u_main (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .load       (main_load_s),
        .d_data     (main_d_data_s),
        .d_regwrite (main_d_regwrite_s),
        .d_dst      (main_d_dst_s),
        .d_tnew     (main_d_tnew_s),
        .q_data     (main_data_s),
        .q_regwrite (main_regwrite_s),
        .q_dst      (main_dst_s),
        .q_tnew     (main_tnew_s)
    );

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .DST_W  (DST_W),
        .TNEW_W (TNEW_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .load       (skid_load_s),
        .d_data     (in_data),
        .d_regwrite (in_regwrite),
        .d_dst      (in_dst),
        .d_tnew     (tnew_cap_s),
        .q_data     (skid_data_s),
        .q_regwrite (skid_regwrite_s),
        .q_dst      (skid_dst_s),
        .q_tnew     (skid_tnew_s)
    );

    // Bubble masking: a stale main entry must never leak to the hazard unit.
    always_comb begin
        if (out_valid_r) begin
            out_data     = main_data_s;
            out_regwrite = main_regwrite_s;
            out_dst      = main_dst_s;
            out_tnew     = main_tnew_s;
        end else begin
            out_data     = {DATA_W{1'b0}};
            out_regwrite = 1'b0;
            out_dst      = {DST_W{1'b0}};
            out_tnew     = {TNEW_W{1'b0}};
        end
    end

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_regwrite;
    logic [4:0]  in_dst;
    logic [1:0]  in_tnew;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_regwrite;
    logic [63:0] out_data;
    logic [4:0]  out_dst;
    logic [1:0]  out_tnew,  occupancy;

    logic        in_ready0, out_valid0, out_regwrite0;
    logic [63:0] out_data0;
    logic [4:0]  out_dst0;
    logic [1:0]  out_tnew0, occupancy0;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_regwrite(in_regwrite), .in_dst(in_dst), .in_tnew(in_tnew),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_regwrite(out_regwrite), .out_dst(out_dst), .out_tnew(out_tnew),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.TNEW_DEC(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_regwrite(in_regwrite), .in_dst(in_dst), .in_tnew(in_tnew),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_regwrite(out_regwrite0), .out_dst(out_dst0), .out_tnew(out_tnew0),
        .occupancy(occupancy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic rw,
                         input logic [4:0] dst, input logic [1:0] tn,
                         input logic ordy, input logic fl);
        in_valid = v; in_data = d; in_regwrite = rw; in_dst = dst;
        in_tnew = tn; out_ready = ordy; flush = fl;
    endtask

    typedef struct {
        logic        iv;   logic [63:0] idata; logic irw; logic [4:0] idst;
        logic [1:0]  itn;  logic ordy; logic fl;
        logic        ev;   logic [63:0] edata; logic erw; logic [4:0] edst;
        logic [1:0]  etn;  logic [1:0] etn0; logic [1:0] eocc; logic erdy;
    } vec_t;

    function automatic vec_t mk(
        input logic iv, input logic [63:0] idata, input logic irw, input logic [4:0] idst,
        input logic [1:0] itn, input logic ordy, input logic fl,
        input logic ev, input logic [63:0] edata, input logic erw, input logic [4:0] edst,
        input logic [1:0] etn, input logic [1:0] etn0, input logic [1:0] eocc, input logic erdy);
        vec_t v;
        v.iv = iv; v.idata = idata; v.irw = irw; v.idst = idst; v.itn = itn;
        v.ordy = ordy; v.fl = fl; v.ev = ev; v.edata = edata; v.erw = erw;
        v.edst = edst; v.etn = etn; v.etn0 = etn0; v.eocc = eocc; v.erdy = erdy;
        return v;
    endfunction

    typedef struct {
        logic [63:0] data; logic rw; logic [4:0] dst; logic [1:0] tn; logic [1:0] tn0;
    } ent_t;

    vec_t vecs[17];
    ent_t q[$];
    ent_t e;

    initial begin
        // Table: inputs applied for one cycle, expectations sampled 1 time unit after the edge.
        //            iv  data         rw    dst    tn   ordy  fl    ev  data         rw    dst    tn    tn0   occ   rdy
        vecs[0]  = mk(1, 64'h1234, 1'b1, 5'd7,  2'd2, 1, 0,   1, 64'h1234, 1'b1, 5'd7,  2'd1, 2'd2, 2'd1, 1);
        vecs[1]  = mk(1, 64'hA1,   1'b1, 5'd1,  2'd3, 1, 0,   1, 64'hA1,   1'b1, 5'd1,  2'd2, 2'd3, 2'd1, 1);
        vecs[2]  = mk(1, 64'hA2,   1'b0, 5'd2,  2'd1, 1, 0,   1, 64'hA2,   1'b0, 5'd2,  2'd0, 2'd1, 2'd1, 1);
        vecs[3]  = mk(1, 64'hA3,   1'b1, 5'd3,  2'd0, 1, 0,   1, 64'hA3,   1'b1, 5'd3,  2'd0, 2'd0, 2'd1, 1);
        vecs[4]  = mk(0, 64'h0,    1'b0, 5'd0,  2'd0, 1, 0,   0, 64'h0,    1'b0, 5'd0,  2'd0, 2'd0, 2'd0, 1);
        // Back-pressure: A, B fill the stage, C waits then follows in order.
        vecs[5]  = mk(1, 64'hB0,   1'b1, 5'd10, 2'd2, 0, 0,   1, 64'hB0,   1'b1, 5'd10, 2'd1, 2'd2, 2'd1, 1);
        vecs[6]  = mk(1, 64'hB1,   1'b1, 5'd11, 2'd1, 0, 0,   1, 64'hB0,   1'b1, 5'd10, 2'd1, 2'd2, 2'd2, 0);
        vecs[7]  = mk(1, 64'hB2,   1'b0, 5'd12, 2'd3, 0, 0,   1, 64'hB0,   1'b1, 5'd10, 2'd1, 2'd2, 2'd2, 0);
        vecs[8]  = mk(1, 64'hB2,   1'b0, 5'd12, 2'd3, 1, 0,   1, 64'hB1,   1'b1, 5'd11, 2'd0, 2'd1, 2'd1, 1);
        vecs[9]  = mk(1, 64'hB2,   1'b0, 5'd12, 2'd3, 1, 0,   1, 64'hB2,   1'b0, 5'd12, 2'd2, 2'd3, 2'd1, 1);
        vecs[10] = mk(0, 64'h0,    1'b0, 5'd0,  2'd0, 1, 0,   0, 64'h0,    1'b0, 5'd0,  2'd0, 2'd0, 2'd0, 1);
        // Flush with a full stage and a pending input, then flush with an accepted input.
        vecs[11] = mk(1, 64'hC0,   1'b1, 5'd5,  2'd1, 0, 0,   1, 64'hC0,   1'b1, 5'd5,  2'd0, 2'd1, 2'd1, 1);
        vecs[12] = mk(1, 64'hC1,   1'b1, 5'd6,  2'd2, 0, 0,   1, 64'hC0,   1'b1, 5'd5,  2'd0, 2'd1, 2'd2, 0);
        vecs[13] = mk(1, 64'hC2,   1'b1, 5'd9,  2'd3, 0, 1,   0, 64'h0,    1'b0, 5'd0,  2'd0, 2'd0, 2'd0, 1);
        vecs[14] = mk(1, 64'hD0,   1'b1, 5'd8,  2'd2, 0, 0,   1, 64'hD0,   1'b1, 5'd8,  2'd1, 2'd2, 2'd1, 1);
        vecs[15] = mk(1, 64'hD1,   1'b1, 5'd4,  2'd3, 0, 1,   0, 64'h0,    1'b0, 5'd0,  2'd0, 2'd0, 2'd0, 1);
        vecs[16] = mk(0, 64'h0,    1'b0, 5'd0,  2'd0, 1, 0,   0, 64'h0,    1'b0, 5'd0,  2'd0, 2'd0, 2'd0, 1);

        drive(0, 64'h0, 0, 5'd0, 2'd0, 1, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        chk("rst_out_data",  out_data,           64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].iv, vecs[i].idata, vecs[i].irw, vecs[i].idst, vecs[i].itn,
                  vecs[i].ordy, vecs[i].fl);
            @(posedge clk); #1;
            chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid},    {63'd0, vecs[i].ev});
            chk($sformatf("v%0d_out_data", i),  out_data,              vecs[i].edata);
            chk($sformatf("v%0d_regwrite", i),  {63'd0, out_regwrite}, {63'd0, vecs[i].erw});
            chk($sformatf("v%0d_out_dst", i),   {59'd0, out_dst},      {59'd0, vecs[i].edst});
            chk($sformatf("v%0d_out_tnew", i),  {62'd0, out_tnew},     {62'd0, vecs[i].etn});
            chk($sformatf("v%0d_tnew_nodec", i),{62'd0, out_tnew0},    {62'd0, vecs[i].etn0});
            chk($sformatf("v%0d_occupancy", i), {62'd0, occupancy},    {62'd0, vecs[i].eocc});
            chk($sformatf("v%0d_in_ready", i),  {63'd0, in_ready},     {63'd0, vecs[i].erdy});
        end

        // Asynchronous reset with two entries held, asserted between edges.
        drive(1, 64'hE0, 1, 5'd9, 2'd3, 0, 0);
        @(posedge clk); #1;
        drive(1, 64'hE1, 1, 5'd3, 2'd2, 0, 0);
        @(posedge clk); #1;
        chk("ar_full_occ", {62'd0, occupancy}, 64'd2);
        drive(0, 64'h0, 0, 5'd0, 2'd0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", {63'd0, out_valid},    64'd0);
        chk("ar_out_data",  out_data,              64'd0);
        chk("ar_regwrite",  {63'd0, out_regwrite}, 64'd0);
        chk("ar_out_dst",   {59'd0, out_dst},      64'd0);
        chk("ar_out_tnew",  {62'd0, out_tnew},     64'd0);
        chk("ar_occupancy", {62'd0, occupancy},    64'd0);
        chk("ar_in_ready",  {63'd0, in_ready},     64'd0);
        #2;
        reset = 1'b0;
        drive(1, 64'hF00D, 1, 5'd17, 2'd2, 1, 0);
        #1;
        chk("ar_rel_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        chk("ar_first_valid", {63'd0, out_valid}, 64'd1);
        chk("ar_first_data",  out_data,           64'hF00D);
        chk("ar_first_dst",   {59'd0, out_dst},   64'd17);
        chk("ar_first_tnew",  {62'd0, out_tnew},  64'd1);

        // Random stress against a reference queue.
        drive(0, 64'h0, 0, 5'd0, 2'd0, 0, 0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic iv, ordy, fl, in_x, out_x;
            chk("st_out_valid", {63'd0, out_valid}, {63'd0, (q.size() != 0)});
            chk("st_occupancy", {62'd0, occupancy}, 64'(q.size()));
            if (q.size() != 0) begin
                chk("st_out_data",  out_data,              q[0].data);
                chk("st_regwrite",  {63'd0, out_regwrite}, {63'd0, q[0].rw});
                chk("st_out_dst",   {59'd0, out_dst},      {59'd0, q[0].dst});
                chk("st_out_tnew",  {62'd0, out_tnew},     {62'd0, q[0].tn});
                chk("st_tnew_nodec",{62'd0, out_tnew0},    {62'd0, q[0].tn0});
            end
            iv   = ($urandom_range(3) != 0);
            ordy = ($urandom_range(2) != 0);
            fl   = ($urandom_range(63) == 0);
            e.data = {$urandom, $urandom};
            e.rw   = 1'($urandom_range(1));
            e.dst  = 5'($urandom_range(31));
            e.tn0  = 2'($urandom_range(3));
            e.tn   = (e.tn0 == 2'd0) ? 2'd0 : e.tn0 - 2'd1;
            drive(iv, e.data, e.rw, e.dst, e.tn0, ordy, fl);
            #1;
            chk("st_in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
            out_ready = ~ordy;
            #1;
            chk("st_in_ready_indep", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
            out_ready = ordy;
            #1;
            in_x  = iv && (q.size() < 2);
            out_x = ordy && (q.size() != 0);
            @(posedge clk); #1;
            if (fl) begin
                q.delete();
            end else begin
                if (out_x) void'(q.pop_front());
                if (in_x) q.push_back(e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_skid
